// File: rtl/pc_unit.sv
// pc_unit: program-counter stage for the five-stage pipeline.
// Holds the PC, computes PC + INC, and selects sequential, branch and jump
// redirects. It also provides stall hold, a one-cycle boot state after reset,
// and halt/resume control with a fetch-valid qualifier for IF.
// Optional feature, enabled by defining PC_ALIGN_CHECK_EN: redirect targets
// are aligned to INC, and a sticky MisalignErr flag records any misaligned
// target.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Halt,
    input  logic             Resume,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             FetchValid,
    output logic             Halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             MisalignErr
`endif
);

    localparam logic [WIDTH-1:0] LP_INC = WIDTH'(INC);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALTED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_redirect;
    logic [WIDTH-1:0] w_raw_target;
    logic [WIDTH-1:0] w_target;
    logic             w_load_err;

    assign w_redirect   = BranchTaken | Jump;
    // EX-stage branch is the older instruction, so it beats a same-cycle jump
    assign w_raw_target = BranchTaken ? BranchTarget : JumpTarget;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] LP_ALIGN_MASK = WIDTH'(INC - 1);

    logic w_misalign;
    logic r_misalign;

    assign w_target   = w_raw_target & ~LP_ALIGN_MASK;
    assign w_misalign = |(w_raw_target & LP_ALIGN_MASK);

    // Sticky misalignment flag; only Reset clears it
    always_ff @(posedge Clk) begin
        if (Reset)
            r_misalign <= 1'b0;
        else if (w_load_err)
            r_misalign <= 1'b1;
    end

    assign MisalignErr = r_misalign;
`else
    assign w_target = w_raw_target;
`endif

    // State and PC registers; reset takes priority over every other input
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state and next PC: redirect > stall/halt hold > sequential
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load_err  = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = Halt ? S_HALTED : S_RUN;
            end
            S_RUN: begin
                // A redirect is still applied when Halt arrives in the same
                // cycle, so resume fetches the redirect target
                if (w_redirect) begin
                    w_pc_nxt = w_target;
`ifdef PC_ALIGN_CHECK_EN
                    w_load_err = w_misalign;
`endif
                end else if (!Stall && !Halt) begin
                    w_pc_nxt = PCAddResult;
                end
                if (Halt)
                    w_state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (!Halt && Resume)
                    w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign PCResult    = r_pc;
    assign PCAddResult = r_pc + LP_INC;
    assign FetchValid  = (r_state == S_RUN);
    assign Halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: checks pc_unit against a behavioural PC model. Two instances
// are used: WIDTH=32 for the main checks and WIDTH=8 for wrap-around.
// Build with PC_ALIGN_CHECK_EN defined to exercise the alignment feature.
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Halt;
    logic        Resume;

    logic [31:0] pc32;
    logic [31:0] add32;
    logic        fv32;
    logic        h32;
    logic [7:0]  pc8;
    logic [7:0]  add8;
    logic        fv8;
    logic        h8;
`ifdef PC_ALIGN_CHECK_EN
    logic        err32;
    logic        err8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc32;
    logic [7:0]  m_pc8;
    logic        m_boot;
    logic        m_halted;
    logic        m_err;

    always #5 Clk = ~Clk;

    pc_unit #(.WIDTH(32), .INC(4), .RESET_VECTOR(32'h0000_0000)) dut32 (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Halt         (Halt),
        .Resume       (Resume),
        .PCResult     (pc32),
        .PCAddResult  (add32),
        .FetchValid   (fv32),
`ifdef PC_ALIGN_CHECK_EN
        .MisalignErr  (err32),
`endif
        .Halted       (h32)
    );

    pc_unit #(.WIDTH(8), .INC(4), .RESET_VECTOR(8'h00)) dut8 (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget[7:0]),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget[7:0]),
        .Halt         (Halt),
        .Resume       (Resume),
        .PCResult     (pc8),
        .PCAddResult  (add8),
        .FetchValid   (fv8),
`ifdef PC_ALIGN_CHECK_EN
        .MisalignErr  (err8),
`endif
        .Halted       (h8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, applied to the current inputs
    task automatic model_edge();
        logic [31:0] t;
        if (Reset) begin
            m_pc32   = 32'h0;
            m_pc8    = 8'h0;
            m_boot   = 1'b1;
            m_halted = 1'b0;
            m_err    = 1'b0;
        end else if (m_boot) begin
            m_boot   = 1'b0;
            m_halted = Halt;
        end else if (m_halted) begin
            if (!Halt && Resume)
                m_halted = 1'b0;
        end else begin
            if (BranchTaken || Jump) begin
                t = BranchTaken ? BranchTarget : JumpTarget;
`ifdef PC_ALIGN_CHECK_EN
                if (t % 4 != 0)
                    m_err = 1'b1;
                t = t - (t % 4);
`endif
                m_pc32 = t;
                m_pc8  = t[7:0];
            end else if (!Stall && !Halt) begin
                m_pc32 = m_pc32 + 32'd4;
                m_pc8  = m_pc8 + 8'd4;
            end
            if (Halt)
                m_halted = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [7:0] e_add8;
        logic       e_fv;
        e_add8 = m_pc8 + 8'd4;
        e_fv   = !m_boot && !m_halted;
        check("pc32",     pc32,        m_pc32);
        check("add32",    add32,       m_pc32 + 32'd4);
        check("fv32",     32'(fv32),   32'(e_fv));
        check("halted32", 32'(h32),    32'(m_halted));
        check("pc8",      32'(pc8),    32'(m_pc8));
        check("add8",     32'(add8),   32'(e_add8));
        check("fv8",      32'(fv8),    32'(e_fv));
        check("halted8",  32'(h8),     32'(m_halted));
`ifdef PC_ALIGN_CHECK_EN
        check("err32",    32'(err32),  32'(m_err));
        check("err8",     32'(err8),   32'(m_err));
`endif
    endtask

    task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic h, input logic r);
        Reset        = rst;
        Stall        = st;
        BranchTaken  = br;
        BranchTarget = bt;
        Jump         = j;
        JumpTarget   = jt;
        Halt         = h;
        Resume       = r;
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        r_rst, r_st, r_br, r_j, r_h, r_r;
        logic [31:0] r_bt, r_jt;

        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0; Halt = 1'b0; Resume = 1'b0;
        m_pc32 = '0; m_pc8 = '0; m_boot = 1'b1; m_halted = 1'b0; m_err = 1'b0;

        // Reset state, boot cycle, then sequential fetch
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_pc", pc32, 32'h0);
        check("rst_add", add32, 32'h4);
        check("rst_fv", 32'(fv32), 32'h0);
        idle(1); check("boot_exit_pc", pc32, 32'h0); check("boot_exit_fv", 32'(fv32), 32'h1);
        idle(1); check("seq_pc4", pc32, 32'h4);
        idle(1); check("seq_pc8", pc32, 32'h8);
        idle(1); check("seq_pcc", pc32, 32'hC);
        idle(1); check("seq_pc10", pc32, 32'h10);

        // Stall hold for three cycles, then advance
        for (int unsigned k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            check("stall_hold", pc32, 32'h10);
        end
        idle(1); check("stall_release", pc32, 32'h14);

        // Branch beats jump and stall; then jump alone
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        check("br_prio", pc32, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
        check("jump", pc32, 32'h200);

        // Wrap on the 8-bit instance
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFC, 1'b0, 1'b0);
        idle(1);
        check("wrap8", 32'(pc8), 32'h0);
        check("nowrap32", pc32, 32'h100);

        // Halt with same-cycle branch, ignored inputs while halted, resume
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
        check("halt_pc", pc32, 32'h80);
        check("halt_flag", 32'(h32), 32'h1);
        check("halt_fv", 32'(fv32), 32'h0);
        for (int unsigned k = 0; k < 5; k++) begin
            step(1'b0, k[0], k[1], 32'h300, k[0], 32'h400, 1'b0, 1'b0);
            check("halt_frozen", pc32, 32'h80);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("halt_beats_resume", 32'(h32), 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("resume_pc", pc32, 32'h80);
        check("resume_fv", 32'(fv32), 32'h1);
        idle(1); check("resume_next", pc32, 32'h84);

        // Halt without redirect holds, then reset while halted
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("halt_hold_pc", pc32, 32'h84);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("rst_halted_pc", pc32, 32'h0);
        check("rst_halted_flag", 32'(h32), 32'h0);

        // Halt during boot is honoured
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        check("boot_halt", 32'(h32), 32'h1);
        check("boot_halt_pc", pc32, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Misaligned jump target
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", pc32, 32'h100);
        check("align_err", 32'(err32), 32'h1);
        idle(3);
        check("align_sticky", 32'(err32), 32'h1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("align_clear", 32'(err32), 32'h0);
`else
        check("raw_target", pc32, 32'h103);
        check("raw_target_add", add32, 32'h107);
`endif

        // Randomised traffic against the model
        for (int unsigned i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(63) == 0);
            r_st  = ($urandom_range(3) == 0);
            r_br  = ($urandom_range(7) == 0);
            r_j   = ($urandom_range(7) == 0);
            r_h   = ($urandom_range(15) == 0);
            r_r   = ($urandom_range(3) == 0);
            r_bt  = $urandom;
            r_jt  = $urandom;
            if ($urandom_range(3) != 0) r_bt[1:0] = 2'b00;
            if ($urandom_range(3) != 0) r_jt[1:0] = 2'b00;
            step(r_rst, r_st, r_br, r_bt, r_j, r_jt, r_h, r_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
